npc_pc_unit: RTL
================

Name: npc_pc_unit

Overview:
- Fetch-stage PC unit for the MIPS pipeline: owns the PC register, computes next PC, and evaluates branches in D.
- Generalises the combinational next-PC calculator with:
  - a parametrised address width and reset/handler vectors;
  - six branch conditions compared in-block;
  - stall hold;
  - exception/interrupt redirect and eret return;
  - a registered delay-slot flag for the instruction entering D.

Parameters:
- PC_W, 32, PC/address width (≥ 28).
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry vector.
- IM_LO, 32'h0000_3000, lowest legal fetch address (used only with the optional feature).
- IM_HI, 32'h0000_6FFC, highest legal fetch address (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hold PC and delay-slot flag (from hazard unit).
- req_i  in  1  exception/interrupt taken this cycle (from CP0).
- eret_i  in  1  eret in D.
- epc_i  in  PC_W  return address for eret.
- br_type_i  in  3  D-stage branch: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as none).
- jal_i  in  1  j/jal in D.
- jr_i  in  1  jr/jalr in D.
- imm_i  in  16  branch offset.
- index_i  in  26  jump index.
- rs_i  in  PC_W  forwarded rs value in D.
- rt_i  in  PC_W  forwarded rt value in D.
- pc_f_o  out  PC_W  current fetch PC.
- pc4_f_o  out  PC_W  pc_f_o + 4.
- npc_o  out  PC_W  next PC (combinational).
- br_taken_o  out  1  D-stage branch condition true.
- bd_d_o  out  1  instruction currently in D sits in a delay slot.
- adel_f_o  out  1  fetch address error (optional feature).

Behaviour:
- Reset state: pc_f_o = RESET_PC, bd_d_o = 0, adel_f_o = 0.
- Branch compare (combinational):
  - EQ/NE compare full rs_i, rt_i.
  - BLEZ/BGTZ/BLTZ/BGEZ are signed on rs_i only; rt_i ignored.
  - br_taken_o = 0 for types 0 and 7.
- npc_o, first match wins:
  1. req_i → HANDLER_PC
  2. eret_i → epc_i
  3. jr_i → rs_i
  4. jal_i → {pc_f_o[PC_W-1:28], index_i, 2'b00}
  5. br_taken_o → pc_f_o + sign_extend({imm_i, 2'b00})
  6. otherwise → pc_f_o + 4
- Arithmetic is modulo 2^PC_W; wrap-around is not flagged.
- PC register update each edge, priority order:
  1. reset → RESET_PC
  2. req_i → HANDLER_PC; overrides stall_i
  3. stall_i → hold
  4. otherwise → npc_o
- eret_i with stall_i = 1 holds; eret takes effect on the first non-stalled cycle.
- bd_d_o register, same priority:
  - reset or req_i → 0
  - stall_i → hold
  - otherwise → (br_type_i ∈ 1..6) | jal_i | jr_i, independent of whether the branch is taken
  - eret_i forces 0 (eret has no delay slot).
- Simultaneous jal_i and jr_i (illegal decode): jr_i wins; no error flag.
- Reset asserted mid-stall or during req_i: reset wins and completes in one cycle.
- Latency:
  - redirect visible on pc_f_o one edge after the request cycle;
  - pc4_f_o and npc_o track pc_f_o in the same cycle.
- No internal stall generation; the hazard unit is responsible for stalling while rs_i/rt_i are not yet forwardable.

Optional Feature:
- Macro: NPC_ADDR_CHECK_EN.
- Defined:
  - adel_f_o = 1 when pc_f_o[1:0] ≠ 0 or pc_f_o < IM_LO or pc_f_o > IM_HI (unsigned).
  - adel_f_o is combinational from the PC register; the PC still advances normally (CP0 raises req_i later).
- Undefined: adel_f_o tied to 0; IM_LO/IM_HI unused; no compare logic synthesised.

Test Plan:
- Reset held 2 cycles, then released with no control inputs → pc_f_o 0x3000, 0x3004, 0x3008 on successive edges; bd_d_o = 0.
- PC = 0x3010; BEQ with rs_i = rt_i = 5, imm_i = 0x0003 → npc_o = 0x301C, br_taken_o = 1, next-edge pc_f_o = 0x301C, bd_d_o = 1. Same case with BGTZ and rs_i = 0xFFFF_FFFF → br_taken_o = 0, npc_o = 0x3014, bd_d_o = 1.
- PC = 0x3020; BNE with rs_i = 1, rt_i = 2, imm_i = 0xFFFC → next pc_f_o = 0x3010 (negative-offset wrap).
- stall_i = 1 for 3 cycles with jal_i = 1, index_i = 0x0000C40 → pc_f_o held; first unstalled edge → pc_f_o = 0x3100. Assert req_i during the stall → pc_f_o = 0x4180, bd_d_o = 0.
- eret_i with epc_i = 0x3050 → next pc_f_o = 0x3050, bd_d_o = 0. Same cycle with req_i = 1 → pc_f_o = 0x4180.
- With NPC_ADDR_CHECK_EN: jr_i with rs_i = 0x3002 → adel_f_o = 1 next cycle. jr_i with rs_i = 0x7000 → adel_f_o = 1. Without the macro, both cases → adel_f_o = 0.

Source files
------------

// File: rtl/npc_pc_unit.sv
// Fetch-stage PC unit: PC register, next-PC selection, D-stage branch compare
// and the registered delay-slot flag for the instruction entering D.
// Optional fetch address check enabled by defining NPC_ADDR_CHECK_EN; when it
// is undefined adel_f_o is tied low and IM_LO/IM_HI drive no logic.
module npc_pc_unit #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [PC_W-1:0] IM_LO      = 32'h0000_3000,
  parameter logic [PC_W-1:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            req_i,
  input  logic            eret_i,
  input  logic [PC_W-1:0] epc_i,
  input  logic [2:0]      br_type_i,
  input  logic            jal_i,
  input  logic            jr_i,
  input  logic [15:0]     imm_i,
  input  logic [25:0]     index_i,
  input  logic [PC_W-1:0] rs_i,
  input  logic [PC_W-1:0] rt_i,
  output logic [PC_W-1:0] pc_f_o,
  output logic [PC_W-1:0] pc4_f_o,
  output logic [PC_W-1:0] npc_o,
  output logic            br_taken_o,
  output logic            bd_d_o,
  output logic            adel_f_o
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LEZ  = 3'd3,
    BR_GTZ  = 3'd4,
    BR_LTZ  = 3'd5,
    BR_GEZ  = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  br_type_e        br_type;
  logic            rs_zero;
  logic            rs_neg;
  logic            is_branch;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jal_target;

  // Jump targets need the upper four bits of the PC, so narrower PCs are unusable.
  if (PC_W < 28 || IM_LO > IM_HI) begin : g_cfg_check
    $error("npc_pc_unit: PC_W must be >= 28 and IM_LO must not exceed IM_HI");
  end

  assign br_type   = br_type_e'(br_type_i);
  assign rs_zero   = (rs_i == '0);
  assign rs_neg    = rs_i[PC_W-1];
  assign is_branch = (br_type != BR_NONE) && (br_type != BR_RSVD);
  assign pc4_f_o   = pc_f_o + PC_W'(4);
  assign br_target = pc_f_o + {{(PC_W-18){imm_i[15]}}, imm_i, 2'b00};

  // Jump target keeps PC bits above 27 and replaces the low 28 bits.
  always_comb begin
    jal_target       = pc_f_o;
    jal_target[27:0] = {index_i, 2'b00};
  end

  // Branch condition; zero-compare types use only the sign bit and a zero test of rs.
  always_comb begin
    br_taken_o = 1'b0;
    case (br_type)
      BR_EQ:   br_taken_o = (rs_i == rt_i);
      BR_NE:   br_taken_o = (rs_i != rt_i);
      BR_LEZ:  br_taken_o = rs_neg | rs_zero;
      BR_GTZ:  br_taken_o = ~rs_neg & ~rs_zero;
      BR_LTZ:  br_taken_o = rs_neg;
      BR_GEZ:  br_taken_o = ~rs_neg;
      default: br_taken_o = 1'b0;
    endcase
  end

  // Next-PC select, highest priority first.
  always_comb begin
    npc_o = pc4_f_o;
    if (req_i) begin
      npc_o = HANDLER_PC;
    end else if (eret_i) begin
      npc_o = epc_i;
    end else if (jr_i) begin
      npc_o = rs_i;
    end else if (jal_i) begin
      npc_o = jal_target;
    end else if (br_taken_o) begin
      npc_o = br_target;
    end
  end

  // PC register: exception redirect overrides a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_o <= RESET_PC;
    end else if (req_i) begin
      pc_f_o <= HANDLER_PC;
    end else if (!stall_i) begin
      pc_f_o <= npc_o;
    end
  end

  // Delay-slot flag: set for any control transfer in D, taken or not; eret has no slot.
  always_ff @(posedge clk) begin
    if (reset || req_i) begin
      bd_d_o <= 1'b0;
    end else if (!stall_i) begin
      bd_d_o <= ~eret_i & (is_branch | jal_i | jr_i);
    end
  end

`ifdef NPC_ADDR_CHECK_EN
  // Fetch address error from the current PC; the PC keeps advancing regardless.
  assign adel_f_o = (pc_f_o[1:0] != 2'b00) || (pc_f_o < IM_LO) || (pc_f_o > IM_HI);
`else
  assign adel_f_o = 1'b0;
`endif

endmodule
